skin_bbox_tracker: RTL and testbench

SKIN_BBOX_TRACKER -- requirements
Module: skin_bbox_tracker

---
 rtl/skin_bbox_tracker_if.sv | 31 +++
 rtl/skin_bbox_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_skin_bbox_tracker.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skin_bbox_tracker_if.sv
// Video pixel and timing bundle carried into and out of the skin bounding-box tracker.
// The "i" side is the incoming stream, the "o" side is the overlaid stream one cycle later.
interface skin_bbox_tracker_if;
  logic [7:0] iR;
  logic [7:0] iG;
  logic [7:0] iB;
  logic       iMask;
  logic       iHSync;
  logic       iVSync;
  logic       iLineValid;
  logic       iFrameValid;
  logic [7:0] oR;
  logic [7:0] oG;
  logic [7:0] oB;
  logic       oHSync;
  logic       oVSync;
  logic       oLineValid;
  logic       oFrameValid;

  // Video source / sink side (drives the input stream, observes the output stream)
  modport master (
    output iR, iG, iB, iMask, iHSync, iVSync, iLineValid, iFrameValid,
    input  oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid
  );

  // Tracker side
  modport slave (
    input  iR, iG, iB, iMask, iHSync, iVSync, iLineValid, iFrameValid,
    output oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid
  );
endinterface

// File: rtl/skin_bbox_tracker.sv
// Skin bounding-box tracker: accumulates the bounding box and pixel count of mask
// pixels over a frame, latches it at frame end, and draws the latched box outline
// onto the following frames. Video and timing are delayed by exactly one cycle.
module skin_bbox_tracker #(
  parameter int          MIN_PIXELS = 16,
  parameter logic [23:0] BOX_RGB    = 24'hFF0000,
  parameter int          XW         = 11,
  parameter int          YW         = 10,
  parameter int          CW         = 20
) (
  input  logic                   iClk,
  input  logic                   iRst,
  skin_bbox_tracker_if.slave     vid,
  output logic                   oBoxValid,
  output logic [XW-1:0]          oXMin,
  output logic [XW-1:0]          oXMax,
  output logic [YW-1:0]          oYMin,
  output logic [YW-1:0]          oYMax,
  output logic [CW-1:0]          oCount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_ALL   = {XW{1'b1}};
  localparam logic [YW-1:0] Y_ALL   = {YW{1'b1}};
  localparam logic [CW-1:0] C_ALL   = {CW{1'b1}};
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

  state_t        state_q, state_d;
  logic          fv_prev_q, lv_prev_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] run_xmin_q, run_xmin_d, run_xmax_q, run_xmax_d;
  logic [YW-1:0] run_ymin_q, run_ymin_d, run_ymax_q, run_ymax_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          box_valid_q, box_valid_d;
  logic [XW-1:0] box_xmin_q, box_xmin_d, box_xmax_q, box_xmax_d;
  logic [YW-1:0] box_ymin_q, box_ymin_d, box_ymax_q, box_ymax_d;
  logic [CW-1:0] box_cnt_q, box_cnt_d;
  logic [23:0]   pix_q, pix_d;
  logic [3:0]    tim_q;

  logic active_s, fv_rise_s, fv_fall_s, lv_fall_s, start_s, accum_s, hit_s;
  logic on_row_s, on_col_s, overlay_s;

  assign active_s  = vid.iFrameValid & vid.iLineValid;
  assign fv_rise_s = ~fv_prev_q & vid.iFrameValid;
  assign fv_fall_s = fv_prev_q & ~vid.iFrameValid;
  assign lv_fall_s = lv_prev_q & ~vid.iLineValid;
  // A new frame may also start in the latch cycle; the latch reads the old
  // running values while the running registers are re-initialised.
  assign start_s   = fv_rise_s & (state_q != ST_ACCUM);
  assign accum_s   = start_s | (state_q == ST_ACCUM);
  assign hit_s     = accum_s & active_s & vid.iMask;

  // Column/row position of the pixel currently on the input
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (active_s) begin
      if (x_q != X_ALL) x_d = x_q + 1'b1;
      else              x_d = x_q;
    end else if (!vid.iLineValid) begin
      x_d = '0;
    end else begin
      x_d = x_q;
    end
    if (!vid.iFrameValid) begin
      y_d = '0;
    end else if (lv_fall_s && (y_q != Y_ALL)) begin
      y_d = y_q + 1'b1;
    end else begin
      y_d = y_q;
    end
  end

  // Frame FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fv_rise_s) state_d = ST_ACCUM;
        else           state_d = ST_IDLE;
      end
      ST_ACCUM: begin
        if (fv_fall_s) state_d = ST_LATCH;
        else           state_d = ST_ACCUM;
      end
      ST_LATCH: begin
        if (fv_rise_s) state_d = ST_ACCUM;
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Running bounding box and count for the frame in progress
  always_comb begin
    if (start_s) begin
      run_xmin_d = X_ALL;
      run_xmax_d = '0;
      run_ymin_d = Y_ALL;
      run_ymax_d = '0;
      run_cnt_d  = '0;
    end else begin
      run_xmin_d = run_xmin_q;
      run_xmax_d = run_xmax_q;
      run_ymin_d = run_ymin_q;
      run_ymax_d = run_ymax_q;
      run_cnt_d  = run_cnt_q;
    end
    if (hit_s) begin
      if (x_q < run_xmin_d) run_xmin_d = x_q;
      else                  run_xmin_d = run_xmin_d;
      if (x_q > run_xmax_d) run_xmax_d = x_q;
      else                  run_xmax_d = run_xmax_d;
      if (y_q < run_ymin_d) run_ymin_d = y_q;
      else                  run_ymin_d = run_ymin_d;
      if (y_q > run_ymax_d) run_ymax_d = y_q;
      else                  run_ymax_d = run_ymax_d;
      if (run_cnt_d != C_ALL) run_cnt_d = run_cnt_d + 1'b1;
      else                    run_cnt_d = run_cnt_d;
    end else begin
      run_cnt_d = run_cnt_d;
    end
  end

  // Latched result, updated only in the latch cycle
  always_comb begin
    box_valid_d = box_valid_q;
    box_xmin_d  = box_xmin_q;
    box_xmax_d  = box_xmax_q;
    box_ymin_d  = box_ymin_q;
    box_ymax_d  = box_ymax_q;
    box_cnt_d   = box_cnt_q;
    if (state_q == ST_LATCH) begin
      box_cnt_d = run_cnt_q;
      if (run_cnt_q >= MIN_CNT) begin
        box_valid_d = 1'b1;
        box_xmin_d  = run_xmin_q;
        box_xmax_d  = run_xmax_q;
        box_ymin_d  = run_ymin_q;
        box_ymax_d  = run_ymax_q;
      end else begin
        box_valid_d = 1'b0;
      end
    end else begin
      box_cnt_d = box_cnt_q;
    end
  end

  // Overlay decision against the box of the last completed frame
  always_comb begin
    on_row_s  = ((y_q == box_ymin_q) || (y_q == box_ymax_q)) &&
                (x_q >= box_xmin_q) && (x_q <= box_xmax_q);
    on_col_s  = ((x_q == box_xmin_q) || (x_q == box_xmax_q)) &&
                (y_q >= box_ymin_q) && (y_q <= box_ymax_q);
    overlay_s = box_valid_q & active_s & (on_row_s | on_col_s);
    if (overlay_s) pix_d = BOX_RGB;
    else           pix_d = {vid.iR, vid.iG, vid.iB};
  end

  // State, counters and output registers
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q     <= ST_IDLE;
      // Sample frame-valid so a frame already running at reset release is not seen as a new one
      fv_prev_q   <= vid.iFrameValid;
      lv_prev_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      run_xmin_q  <= '0;
      run_xmax_q  <= '0;
      run_ymin_q  <= '0;
      run_ymax_q  <= '0;
      run_cnt_q   <= '0;
      box_valid_q <= 1'b0;
      box_xmin_q  <= '0;
      box_xmax_q  <= '0;
      box_ymin_q  <= '0;
      box_ymax_q  <= '0;
      box_cnt_q   <= '0;
      pix_q       <= 24'h000000;
      tim_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      fv_prev_q   <= vid.iFrameValid;
      lv_prev_q   <= vid.iLineValid;
      x_q         <= x_d;
      y_q         <= y_d;
      run_xmin_q  <= run_xmin_d;
      run_xmax_q  <= run_xmax_d;
      run_ymin_q  <= run_ymin_d;
      run_ymax_q  <= run_ymax_d;
      run_cnt_q   <= run_cnt_d;
      box_valid_q <= box_valid_d;
      box_xmin_q  <= box_xmin_d;
      box_xmax_q  <= box_xmax_d;
      box_ymin_q  <= box_ymin_d;
      box_ymax_q  <= box_ymax_d;
      box_cnt_q   <= box_cnt_d;
      pix_q       <= pix_d;
      tim_q       <= {vid.iHSync, vid.iVSync, vid.iLineValid, vid.iFrameValid};
    end
  end

  assign vid.oR          = pix_q[23:16];
  assign vid.oG          = pix_q[15:8];
  assign vid.oB          = pix_q[7:0];
  assign vid.oHSync      = tim_q[3];
  assign vid.oVSync      = tim_q[2];
  assign vid.oLineValid  = tim_q[1];
  assign vid.oFrameValid = tim_q[0];
  assign oBoxValid       = box_valid_q;
  assign oXMin           = box_xmin_q;
  assign oXMax           = box_xmax_q;
  assign oYMin           = box_ymin_q;
  assign oYMax           = box_ymax_q;
  assign oCount          = box_cnt_q;

endmodule

// File: tb/tb_skin_bbox_tracker.sv
// Directed bench for skin_bbox_tracker: 16x8 frames on two instances (MIN_PIXELS 8 and 1).
module tb_skin_bbox_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [23:0] rgb = 24'h000000;
  logic mk = 1'b0, hs = 1'b0, vs = 1'b0, lv = 1'b0, fv = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [23:0] cap8 [128];
  logic [23:0] cap1 [128];

  logic        bv8, bv1;
  logic [10:0] xmin8, xmax8, xmin1, xmax1;
  logic [9:0]  ymin8, ymax8, ymin1, ymax1;
  logic [19:0] cnt8, cnt1;

  skin_bbox_tracker_if vif8();
  skin_bbox_tracker_if vif1();

  assign vif8.iR = rgb[23:16]; assign vif8.iG = rgb[15:8]; assign vif8.iB = rgb[7:0];
  assign vif8.iMask = mk; assign vif8.iHSync = hs; assign vif8.iVSync = vs;
  assign vif8.iLineValid = lv; assign vif8.iFrameValid = fv;
  assign vif1.iR = rgb[23:16]; assign vif1.iG = rgb[15:8]; assign vif1.iB = rgb[7:0];
  assign vif1.iMask = mk; assign vif1.iHSync = hs; assign vif1.iVSync = vs;
  assign vif1.iLineValid = lv; assign vif1.iFrameValid = fv;

  skin_bbox_tracker #(.MIN_PIXELS(8), .BOX_RGB(24'hFF0000)) dut8 (
    .iClk(clk), .iRst(rst), .vid(vif8), .oBoxValid(bv8),
    .oXMin(xmin8), .oXMax(xmax8), .oYMin(ymin8), .oYMax(ymax8), .oCount(cnt8));

  skin_bbox_tracker #(.MIN_PIXELS(1), .BOX_RGB(24'hFF0000)) dut1 (
    .iClk(clk), .iRst(rst), .vid(vif1), .oBoxValid(bv1),
    .oXMin(xmin1), .oXMax(xmax1), .oYMin(ymin1), .oYMax(ymax1), .oCount(cnt1));

  always #5 clk = ~clk;

  function automatic logic mask_at(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 3 && x <= 6 && y >= 2 && y <= 4);
      2: return (y == 0 && x <= 1) || (x == 10 && y == 5) || (x == 11 && y == 6) || (x == 12 && y == 7);
      3: return (x == 15 && y == 7);
      default: return 1'b0;
    endcase
  endfunction

  // Drives one 16x8 frame; captures each pixel's output one cycle after it was driven.
  task automatic run_frame(input int mode);
    int px = 0, py = 0;
    bit pend = 1'b0;
    @(negedge clk); fv = 1'b1; lv = 1'b0; vs = 1'b1;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        @(negedge clk);
        if (pend) begin
          cap8[py*16+px] = {vif8.oR, vif8.oG, vif8.oB};
          cap1[py*16+px] = {vif1.oR, vif1.oG, vif1.oB};
        end
        vs = 1'b0; lv = 1'b1; mk = mask_at(mode, x, y); px = x; py = y; pend = 1'b1;
      end
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        if (pend) begin
          cap8[py*16+px] = {vif8.oR, vif8.oG, vif8.oB};
          cap1[py*16+px] = {vif1.oR, vif1.oG, vif1.oB};
        end
        pend = 1'b0; lv = 1'b0; mk = 1'b0; hs = (b == 1);
      end
    end
    @(negedge clk); fv = 1'b0; hs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; rgb = 24'h55AA33; hs = 1'b1; vs = 1'b1; lv = 1'b1; fv = 1'b0; mk = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vif8.oR, vif8.oG, vif8.oB} !== 24'h000000) begin
      failures++; $display("FAIL reset_rgb got=%h exp=000000", {vif8.oR, vif8.oG, vif8.oB});
    end
    checks++;
    if ({vif8.oHSync, vif8.oVSync, vif8.oLineValid, vif8.oFrameValid} !== 4'b0000) begin
      failures++; $display("FAIL reset_timing got=%b exp=0000",
        {vif8.oHSync, vif8.oVSync, vif8.oLineValid, vif8.oFrameValid});
    end
    checks++;
    if ({bv8, xmin8, xmax8, ymin8, ymax8, cnt8} !== 63'd0) begin
      failures++; $display("FAIL reset_box got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp all 0",
        bv8, xmin8, xmax8, ymin8, ymax8, cnt8);
    end
    @(negedge clk); rst = 1'b1; hs = 1'b0; vs = 1'b0; lv = 1'b0; mk = 1'b0; rgb = 24'h102030;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_box_latch;
    int bad = 0;
    run_frame(1);
    checks++;
    if ({bv8, xmin8, xmax8, ymin8, ymax8, cnt8} !== {1'b1, 11'd3, 11'd6, 10'd2, 10'd4, 20'd12}) begin
      failures++; $display("FAIL box_latch got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp v=1 x=3..6 y=2..4 c=12",
        bv8, xmin8, xmax8, ymin8, ymax8, cnt8);
    end
    for (int i = 0; i < 128; i++) if (cap8[i] !== 24'h102030) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL first_frame_no_overlay got %0d coloured pixels exp 0", bad);
    end
  endtask

  task automatic test_overlay;
    logic [23:0] e;
    run_frame(1);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        if (((y == 2 || y == 4) && x >= 3 && x <= 6) || ((x == 3 || x == 6) && y >= 2 && y <= 4))
          e = 24'hFF0000;
        else
          e = 24'h102030;
        checks++;
        if (cap8[y*16+x] !== e) begin
          failures++; $display("FAIL overlay x=%0d y=%0d got=%h exp=%h", x, y, cap8[y*16+x], e);
        end
      end
    end
    checks++;
    if (cap8[3*16+4] !== 24'h102030) begin
      failures++; $display("FAIL overlay_interior got=%h exp=102030", cap8[3*16+4]);
    end
  endtask

  task automatic test_below_min;
    int bad = 0;
    run_frame(2);
    checks++;
    if ({bv8, xmin8, xmax8, ymin8, ymax8, cnt8} !== {1'b0, 11'd3, 11'd6, 10'd2, 10'd4, 20'd5}) begin
      failures++; $display("FAIL below_min got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp v=0 x=3..6 y=2..4 c=5",
        bv8, xmin8, xmax8, ymin8, ymax8, cnt8);
    end
    run_frame(1);
    for (int i = 0; i < 128; i++) if (cap8[i] !== 24'h102030) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL below_min_no_overlay got %0d coloured pixels exp 0", bad);
    end
  endtask

  task automatic test_single;
    logic [23:0] e;
    run_frame(3);
    checks++;
    if ({bv1, xmin1, xmax1, ymin1, ymax1, cnt1} !== {1'b1, 11'd15, 11'd15, 10'd7, 10'd7, 20'd1}) begin
      failures++; $display("FAIL single got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp v=1 x=15..15 y=7..7 c=1",
        bv1, xmin1, xmax1, ymin1, ymax1, cnt1);
    end
    run_frame(0);
    for (int i = 0; i < 128; i++) begin
      e = (i == 7*16+15) ? 24'hFF0000 : 24'h102030;
      checks++;
      if (cap1[i] !== e) begin
        failures++; $display("FAIL single_overlay x=%0d y=%0d got=%h exp=%h", i % 16, i / 16, cap1[i], e);
      end
    end
    checks++;
    if ({bv1, xmin1, xmax1, ymin1, ymax1, cnt1} !== {1'b0, 11'd15, 11'd15, 10'd7, 10'd7, 20'd0}) begin
      failures++; $display("FAIL zero_count got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp v=0 x=15..15 y=7..7 c=0",
        bv1, xmin1, xmax1, ymin1, ymax1, cnt1);
    end
  endtask

  task automatic test_empty_frame;
    run_frame(1);
    @(negedge clk); fv = 1'b1;
    @(negedge clk); fv = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bv8, cnt8} !== {1'b0, 20'd0}) begin
      failures++; $display("FAIL empty_frame got v=%b c=%0d exp v=0 c=0", bv8, cnt8);
    end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk); fv = 1'b1;
    for (int y = 0; y < 8; y++) begin
      if (y == 3) begin
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        checks++;
        if ({vif8.oR, vif8.oG, vif8.oB, bv8, cnt8} !== 45'd0) begin
          failures++; $display("FAIL midreset_zero got rgb=%h v=%b c=%0d exp 0",
            {vif8.oR, vif8.oG, vif8.oB}, bv8, cnt8);
        end
      end
      for (int x = 0; x < 16; x++) begin
        @(negedge clk); lv = 1'b1; mk = mask_at(1, x, y);
      end
      repeat (3) begin @(negedge clk); lv = 1'b0; mk = 1'b0; end
    end
    @(negedge clk); fv = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bv8, xmin8, xmax8, ymin8, ymax8, cnt8} !== 63'd0) begin
      failures++; $display("FAIL midreset_ignored got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp all 0",
        bv8, xmin8, xmax8, ymin8, ymax8, cnt8);
    end
    run_frame(1);
    checks++;
    if ({bv8, xmin8, xmax8, ymin8, ymax8, cnt8} !== {1'b1, 11'd3, 11'd6, 10'd2, 10'd4, 20'd12}) begin
      failures++; $display("FAIL midreset_recover got v=%b x=%0d..%0d y=%0d..%0d c=%0d exp v=1 x=3..6 y=2..4 c=12",
        bv8, xmin8, xmax8, ymin8, ymax8, cnt8);
    end
  endtask

  task automatic test_timing;
    logic [3:0]  pt, gt;
    logic [23:0] prgb;
    logic        pact;
    @(negedge clk);
    {hs, vs, lv, fv} = 4'($urandom_range(0, 15)); rgb = 24'($urandom);
    pt = {hs, vs, lv, fv}; prgb = rgb; pact = lv & fv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gt = {vif8.oHSync, vif8.oVSync, vif8.oLineValid, vif8.oFrameValid};
      checks++;
      if (gt !== pt) begin
        failures++; $display("FAIL timing cyc=%0d got=%b exp=%b", i, gt, pt);
      end
      if (!pact) begin
        checks++;
        if ({vif8.oR, vif8.oG, vif8.oB} !== prgb) begin
          failures++; $display("FAIL passthru cyc=%0d got=%h exp=%h", i, {vif8.oR, vif8.oG, vif8.oB}, prgb);
        end
      end
      {hs, vs, lv, fv} = 4'($urandom_range(0, 15)); rgb = 24'($urandom);
      pt = {hs, vs, lv, fv}; prgb = rgb; pact = lv & fv;
    end
    @(negedge clk); {hs, vs, lv, fv} = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_box_latch();
    test_overlay();
    test_below_min();
    test_single();
    test_empty_frame();
    test_reset_midframe();
    test_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
